vape_violation_reset_ctrl: RTL and testbench



---
 rtl/vape_pkg.sv | 13 +
 rtl/vape_sat_counter.sv | 19 +
 rtl/vape_violation_reset_ctrl.sv | 114 +++++++++++
 tb/tb_vape_violation_reset_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/vape_pkg.sv
// Shared definitions for the VAPE monitor bank and its violation/reset controller.
package vape_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    ASSERT = 2'd1,
    BOOT   = 2'd2
  } vape_state_e;

  // PC at which every monitor re-arms after a CPU reset.
  localparam logic [15:0] RESET_HANDLER_DEF = 16'h0000;

endpackage

// File: rtl/vape_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module vape_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (inc && (cnt != {W{1'b1}}))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/vape_violation_reset_ctrl.sv
// Turns a dropped monitor exec bit into a timed CPU reset request, records the
// cause and tracks the reboot until every monitor has re-armed.
module vape_violation_reset_ctrl
  import vape_pkg::*;
#(
  parameter int          N_MON         = 4,
  parameter int          HOLD_CYCLES   = 8,
  parameter logic [15:0] RESET_HANDLER = RESET_HANDLER_DEF,
  parameter int          BOOT_TIMEOUT  = 64,
  parameter int          CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_MON-1:0] exec_vec,
  input  logic [15:0]      pc,
  input  logic             cause_clr,
  output logic             reset_req,
  output logic [N_MON-1:0] cause,
  output logic [CNT_W-1:0] viol_cnt,
  output logic             armed
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int TO_W   = $clog2(BOOT_TIMEOUT + 1);
  // Hold counts down to zero, so loading H-1 gives exactly H ASSERT cycles.
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(BOOT_TIMEOUT);

  vape_state_e       state, state_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [TO_W-1:0]   to_cnt, to_n;
  logic              seen_rh, seen_n;
  logic [N_MON-1:0]  new_bits, cause_n;
  logic              viol_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BOOT;
      hold_cnt  <= '0;
      to_cnt    <= '0;
      seen_rh   <= 1'b0;
      cause     <= '0;
      reset_req <= 1'b0;
      armed     <= 1'b0;
    end else begin
      state     <= state_n;
      hold_cnt  <= hold_n;
      to_cnt    <= to_n;
      seen_rh   <= seen_n;
      cause     <= cause_n;
      reset_req <= (state_n == ASSERT);
      armed     <= (state_n == RUN);
    end
  end

  always_comb begin
    state_n  = state;
    hold_n   = hold_cnt;
    to_n     = to_cnt;
    seen_n   = seen_rh;
    new_bits = '0;
    viol_inc = 1'b0;
    case (state)
      RUN: begin
        if (!(&exec_vec)) begin
          state_n  = ASSERT;
          new_bits = ~exec_vec;
          viol_inc = 1'b1;
          hold_n   = HOLD_LOAD;
        end
      end
      ASSERT: begin
        // Late drops only extend the cause record; the hold is not restarted.
        new_bits = ~exec_vec;
        if (hold_cnt == '0) begin
          state_n = BOOT;
          to_n    = '0;
          seen_n  = 1'b0;
        end else begin
          hold_n = hold_cnt - 1'b1;
        end
      end
      BOOT: begin
        to_n = to_cnt + 1'b1;
        if (seen_rh) begin
          if (&exec_vec) begin
            state_n = RUN;
          end
          seen_n = 1'b0;
        end else if (pc == RESET_HANDLER) begin
          seen_n = 1'b1;
        end
        // Reboot never completed: retry the reset as a fresh violation.
        if (state_n != RUN && to_n == TO_MAX) begin
          state_n  = ASSERT;
          new_bits = ~exec_vec;
          viol_inc = 1'b1;
          hold_n   = HOLD_LOAD;
        end
      end
      default: state_n = BOOT;
    endcase
    cause_n = (cause_clr ? '0 : cause) | new_bits;
  end

  vape_sat_counter #(.W(CNT_W)) u_viol_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (viol_inc),
    .cnt (viol_cnt)
  );

endmodule

// File: tb/tb_vape_violation_reset_ctrl.sv
// Directed bench for the violation/reset controller with hand-computed expectations.
module tb_vape_violation_reset_ctrl;
  import vape_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  exec_vec;
  logic [15:0] pc;
  logic        cause_clr;
  logic        reset_req;
  logic [3:0]  cause;
  logic [7:0]  viol_cnt;
  logic        armed;

  int n_assert = 0;
  int n_fail   = 0;
  int n;

  always #5 clk = ~clk;

  vape_violation_reset_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .exec_vec  (exec_vec),
    .pc        (pc),
    .cause_clr (cause_clr),
    .reset_req (reset_req),
    .cause     (cause),
    .viol_cnt  (viol_cnt),
    .armed     (armed)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts consecutive cycles with reset_req high, starting from the current one.
  task automatic measure_hold(output int cnt);
    cnt = 0;
    while (reset_req === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
  endtask

  // Counts cycles until reset_req rises.
  task automatic measure_boot(output int cnt);
    cnt = 0;
    while (reset_req === 1'b0 && cnt < 100) begin
      cnt++;
      tick();
    end
  endtask

  task automatic recover();
    exec_vec = 4'hF;
    pc = 16'h0000;
    tick();
    pc = 16'h1234;
    tick();
  endtask

  task automatic viol_cycle();
    int h;
    exec_vec = 4'b1110;
    tick();
    exec_vec = 4'hF;
    measure_hold(h);
    recover();
  endtask

  initial begin
    rst = 1'b1; exec_vec = 4'hF; pc = 16'h1234; cause_clr = 1'b0;
    tick(); tick();
    chk("rst_reset_req", 32'(reset_req), 32'd0);
    chk("rst_cause",     32'(cause),     32'd0);
    chk("rst_viol_cnt",  32'(viol_cnt),  32'd0);
    chk("rst_armed",     32'(armed),     32'd0);
    chk("rst_state",     32'(dut.state), 32'(BOOT));

    // Boot into RUN
    rst = 1'b0; pc = 16'h0000;
    tick();
    chk("boot_armed_early", 32'(armed), 32'd0);
    pc = 16'h1234;
    tick();
    chk("boot_armed",     32'(armed),     32'd1);
    chk("boot_reset_req", 32'(reset_req), 32'd0);

    // Single-cycle violation on bit 1
    exec_vec = 4'b1101;
    tick();
    chk("v1_reset_req", 32'(reset_req), 32'd1);
    chk("v1_cause",     32'(cause),     32'h2);
    chk("v1_viol_cnt",  32'(viol_cnt),  32'd1);
    chk("v1_armed",     32'(armed),     32'd0);
    exec_vec = 4'hF;
    measure_hold(n);
    chk("v1_hold_len", 32'(n), 32'd8);
    chk("v1_state",    32'(dut.state), 32'(BOOT));

    // Boot timeout with bit 2 killed and pc never at the handler
    exec_vec = 4'b1011;
    measure_boot(n);
    chk("to_boot_len", 32'(n),        32'd64);
    chk("to_viol_cnt", 32'(viol_cnt), 32'd2);
    chk("to_cause",    32'(cause),    32'h6);
    exec_vec = 4'hF;
    measure_hold(n);
    chk("to_hold_len", 32'(n), 32'd8);

    // Handler reached but a monitor still dead: stay in BOOT
    exec_vec = 4'b1011; pc = 16'h0000;
    tick();
    pc = 16'h1234;
    tick();
    chk("partial_armed", 32'(armed),     32'd0);
    chk("partial_state", 32'(dut.state), 32'(BOOT));
    recover();
    chk("rec1_armed", 32'(armed), 32'd1);

    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    chk("clr_cause", 32'(cause), 32'h0);

    // Bit 3 drops mid-hold
    exec_vec = 4'b1101;
    tick();
    exec_vec = 4'hF;
    tick();
    exec_vec = 4'b0111;
    tick();
    exec_vec = 4'hF;
    chk("mid_cause",    32'(cause),     32'hA);
    chk("mid_viol_cnt", 32'(viol_cnt),  32'd3);
    chk("mid_reset_req",32'(reset_req), 32'd1);
    measure_hold(n);
    chk("mid_hold_rest", 32'(n),       32'd6);
    chk("mid_viol_end",  32'(viol_cnt), 32'd3);
    recover();
    chk("rec2_armed", 32'(armed), 32'd1);

    // Clear and new violation on the same edge: new bits win
    cause_clr = 1'b1; exec_vec = 4'b1110;
    tick();
    cause_clr = 1'b0; exec_vec = 4'hF;
    chk("clrnew_cause",    32'(cause),    32'h1);
    chk("clrnew_viol_cnt", 32'(viol_cnt), 32'd4);
    measure_hold(n);
    chk("clrnew_hold_len", 32'(n), 32'd8);
    recover();

    // Saturation: 251 more violations reach 255, one further stays there
    for (int i = 0; i < 251; i++) viol_cycle();
    chk("sat_255", 32'(viol_cnt), 32'hFF);
    chk("sat_armed", 32'(armed), 32'd1);
    viol_cycle();
    chk("sat_hold", 32'(viol_cnt), 32'hFF);

    // rst on the 3rd ASSERT cycle
    exec_vec = 4'b1110;
    tick();
    exec_vec = 4'hF;
    tick();
    tick();
    chk("rst3_pre_req", 32'(reset_req), 32'd1);
    rst = 1'b1;
    tick();
    chk("rst3_reset_req", 32'(reset_req), 32'd0);
    chk("rst3_cause",     32'(cause),     32'h0);
    chk("rst3_viol_cnt",  32'(viol_cnt),  32'd0);
    chk("rst3_state",     32'(dut.state), 32'(BOOT));
    chk("rst3_armed",     32'(armed),     32'd0);
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
